// File: rtl/fp_addsub_pipe_if.sv
// Stream bundle for fp_addsub_pipe: operand beat in, result beat out.
// slave = the adder side, master = the producer/consumer side.
interface fp_addsub_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] number_1;
  logic [W-1:0] number_2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         flag_ovf;
  logic         flag_unf;
  logic         flag_nan;

  modport slave (
    input  in_valid, op_sub,
    input  number_1, number_2,
    input  out_ready,
    output in_ready, out_valid, out,
    output flag_ovf, flag_unf, flag_nan
  );

  modport master (
    output in_valid, op_sub,
    output number_1, number_2,
    output out_ready,
    input  in_ready, out_valid, out,
    input  flag_ovf, flag_unf, flag_nan
  );
endinterface

// File: rtl/fp_addsub_pipe.sv
// 3-stage float add/sub (align, add+normalise, round+pack), RNE.
// Ports: clk, rst (async high), bus (fp_addsub_pipe_if.slave).
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic             clk,
  input  logic             rst,
  fp_addsub_pipe_if.slave  bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 4;
  localparam int XW = EXP_W + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;

  logic out_valid_q;
  logic adv;
  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;

  // ---------------- S1: unpack, swap, align ----------------
  logic             sa, sb_raw, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  assign {sa, ea, fa}     = bus.number_1;
  assign {sb_raw, eb, fb} = bus.number_2;
  assign sb = sb_raw ^ bus.op_sub;

  logic a_nan, b_nan, a_inf, b_inf;
  assign a_nan = (ea == EMAX) && (fa != '0);
  assign b_nan = (eb == EMAX) && (fb != '0);
  assign a_inf = (ea == EMAX) && (fa == '0);
  assign b_inf = (eb == EMAX) && (fb == '0);

  // exp==0 operands (zero or subnormal) act as zero
  logic [MAN_W:0] ma, mb;
  assign ma = (ea == '0) ? '0 : {1'b1, fa};
  assign mb = (eb == '0) ? '0 : {1'b1, fb};

  logic             a_ge;
  logic             s_big;
  logic [EXP_W-1:0] e_big, e_sml, dexp;
  logic [MAN_W:0]   m_big, m_sml;
  assign a_ge  = {ea, ma} >= {eb, mb};
  assign s_big = a_ge ? sa : sb;
  assign e_big = a_ge ? ea : eb;
  assign e_sml = a_ge ? eb : ea;
  assign m_big = a_ge ? ma : mb;
  assign m_sml = a_ge ? mb : ma;
  assign dexp  = e_big - e_sml;

  // shift into a double-width window; the low half feeds sticky
  int              sh;
  logic [2*MW-1:0] wide;
  logic [MW-1:0]   ms_al;
  always_comb begin
    sh    = (int'(dexp) > MW) ? MW : int'(dexp);
    wide  = {m_sml, 3'b000, {MW{1'b0}}} >> sh;
    ms_al = {wide[2*MW-1:MW+1],
             wide[MW] | (|wide[MW-1:0])};
  end

  logic             s1_valid_q, s1_nan_q, s1_inf_q;
  logic             s1_isgn_q, s1_sign_q, s1_zsgn_q;
  logic             s1_sub_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [MW-1:0]    s1_mb_q, s1_ms_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_nan_q   <= 1'b0;
      s1_inf_q   <= 1'b0;
      s1_isgn_q  <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zsgn_q  <= 1'b0;
      s1_sub_q   <= 1'b0;
      s1_exp_q   <= '0;
      s1_mb_q    <= '0;
      s1_ms_q    <= '0;
    end else if (adv) begin
      s1_valid_q <= bus.in_valid;
      s1_nan_q   <= a_nan || b_nan ||
                    (a_inf && b_inf && (sa != sb));
      s1_inf_q   <= a_inf || b_inf;
      s1_isgn_q  <= a_inf ? sa : sb;
      s1_sign_q  <= s_big;
      // an exact zero is -0 only when both signs are negative
      s1_zsgn_q  <= sa && sb;
      s1_sub_q   <= sa != sb;
      s1_exp_q   <= e_big;
      s1_mb_q    <= {m_big, 3'b000};
      s1_ms_q    <= ms_al;
    end
  end

  // ---------------- S2: add, normalise ----------------
  logic [MW:0]          sum;
  int                   lz;
  logic signed [XW-1:0] e_in, e2_d;
  logic [MW-1:0]        m2_d;

  assign e_in = $signed({2'b00, s1_exp_q});

  always_comb begin
    sum = s1_sub_q ? {1'b0, s1_mb_q} - {1'b0, s1_ms_q}
                   : {1'b0, s1_mb_q} + {1'b0, s1_ms_q};
    lz = 0;
    for (int i = 0; i < MW; i++)
      if (sum[i]) lz = MW - 1 - i;
    if (sum[MW]) begin
      m2_d = {sum[MW:2], sum[1] | sum[0]};
      e2_d = e_in + $signed(XW'(1));
    end else begin
      m2_d = sum[MW-1:0] << lz;
      e2_d = e_in - $signed(XW'(lz));
    end
  end

  logic                 s2_valid_q, s2_nan_q, s2_inf_q;
  logic                 s2_isgn_q, s2_sign_q, s2_zsgn_q;
  logic                 s2_zero_q;
  logic signed [XW-1:0] s2_exp_q;
  logic [MW-1:0]        s2_mant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_nan_q   <= 1'b0;
      s2_inf_q   <= 1'b0;
      s2_isgn_q  <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zsgn_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_mant_q  <= '0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      s2_nan_q   <= s1_nan_q;
      s2_inf_q   <= s1_inf_q;
      s2_isgn_q  <= s1_isgn_q;
      s2_sign_q  <= s1_sign_q;
      s2_zsgn_q  <= s1_zsgn_q;
      s2_zero_q  <= sum == '0;
      s2_exp_q   <= e2_d;
      s2_mant_q  <= m2_d;
    end
  end

  // ---------------- S3: round, pack ----------------
  logic                 rnd_up;
  logic [MAN_W+1:0]     rnd;
  logic signed [XW-1:0] e3;
  logic [MAN_W-1:0]     frac;
  logic [W-1:0]         out_d;
  logic                 ovf_d, unf_d, nan_d;

  assign rnd_up = s2_mant_q[2] &&
                  (s2_mant_q[1] || s2_mant_q[0] ||
                   s2_mant_q[3]);

  always_comb begin
    rnd  = {1'b0, s2_mant_q[MW-1:3]} +
           (MAN_W+2)'(rnd_up);
    e3   = s2_exp_q + $signed(XW'(rnd[MAN_W+1]));
    frac = rnd[MAN_W+1] ? rnd[MAN_W:1]
                        : rnd[MAN_W-1:0];
    ovf_d = 1'b0;
    unf_d = 1'b0;
    nan_d = 1'b0;
    out_d = {s2_sign_q, e3[EXP_W-1:0], frac};
    if (s2_nan_q) begin
      nan_d = 1'b1;
      out_d = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (s2_inf_q) begin
      out_d = {s2_isgn_q, EMAX, {MAN_W{1'b0}}};
    end else if (s2_zero_q) begin
      out_d = {s2_zsgn_q, {(W-1){1'b0}}};
    end else if (e3 >= $signed({2'b00, EMAX})) begin
      ovf_d = 1'b1;
      out_d = {s2_sign_q, EMAX, {MAN_W{1'b0}}};
    end else if (e3 < $signed(XW'(1))) begin
      unf_d = 1'b1;
      out_d = {s2_sign_q, {(W-1){1'b0}}};
    end
  end

  logic [W-1:0] out_q;
  logic         ovf_q, unf_q, nan_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      nan_q       <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) out_q <= out_d;
      ovf_q <= s2_valid_q && ovf_d;
      unf_q <= s2_valid_q && unf_d;
      nan_q <= s2_valid_q && nan_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.flag_ovf  = ovf_q;
  assign bus.flag_unf  = unf_q;
  assign bus.flag_nan  = nan_q;
endmodule
